// File: rtl/tracker_mode_gen_if.sv
// Tracker drive-mode bundle: run enable and raw sensor in, registered drive code and status out.
// The slave modport is the mode generator; the master side is the controller driving it.
interface tracker_mode_gen_if;
  logic       en;
  logic [2:0] sensor;
  logic [2:0] mode;
  logic       mode_chg;
  logic       lost;

  modport master (
    output en,
    output sensor,
    input  mode,
    input  mode_chg,
    input  lost
  );

  modport slave (
    input  en,
    input  sensor,
    output mode,
    output mode_chg,
    output lost
  );
endinterface

// File: rtl/tracker_mode_gen.sv
// IR line-tracker mode generator: synchronizes and debounces a 3-bit sensor, then
// maps it to a motor drive code, falling back to a search/end sequence when the line is lost.
module tracker_mode_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned LOST_TIMEOUT    = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  tracker_mode_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StTrack, StLost, StEnd} state_e;
  typedef enum logic [1:0] {SideNone, SideLeft, SideRight} side_e;

  localparam logic [31:0] DebMax  = 32'(DEBOUNCE_CYCLES);
  localparam logic [31:0] DebLoad = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] ToLast  = 32'(LOST_TIMEOUT - 1);

  logic [2:0]  sync1_q, sync1_d;
  logic [2:0]  sync2_q, sync2_d;
  logic [31:0] stable_q, stable_d;
  logic [2:0]  deb_q, deb_d;
  logic [31:0] to_q, to_d;
  state_e      state_q, state_d;
  side_e       side_q, side_d;
  logic [2:0]  mode_q, mode_d;
  logic        chg_q, chg_d;
  logic        lost_q, lost_d;

  function automatic logic [2:0] map_code(input logic [2:0] v);
    logic [2:0] m;
    case (v)
      3'b111:  m = 3'b000;
      3'b011:  m = 3'b011;
      3'b001:  m = 3'b001;
      3'b110:  m = 3'b110;
      3'b100:  m = 3'b100;
      3'b010:  m = 3'b101;
      3'b101:  m = 3'b010;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic side_e next_side(input logic [2:0] v, input side_e cur);
    side_e s;
    case (v)
      3'b001, 3'b011: s = SideRight;
      3'b100, 3'b110: s = SideLeft;
      default:        s = cur;
    endcase
    return s;
  endfunction

  // Synchronizer and debounce: sync1_q is the value sync2_q takes next, so a mismatch
  // marks the edge at which the synchronized vector changes.
  always_comb begin
    sync1_d = bus.sensor;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    if (sync1_q != sync2_q) begin
      stable_d = '0;
    end else if (stable_q == DebMax) begin
      stable_d = stable_q;
    end else begin
      stable_d = stable_q + 32'd1;
    end
    if ((sync1_q == sync2_q) && (stable_q == DebLoad)) begin
      deb_d = sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    side_d  = side_q;
    to_d    = to_q;
    if (!bus.en) begin
      state_d = StIdle;
      mode_d  = 3'b000;
      side_d  = SideNone;
      to_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StTrack;
          mode_d  = 3'b000;
        end
        StTrack: begin
          if (deb_q == 3'b000) begin
            state_d = StLost;
            to_d    = '0;
            case (side_q)
              SideRight: mode_d = 3'b001;
              SideLeft:  mode_d = 3'b100;
              default:   mode_d = 3'b111;
            endcase
          end else begin
            mode_d = map_code(deb_q);
            side_d = next_side(deb_q, side_q);
          end
        end
        StLost: begin
          // Reacquisition is checked first so it wins over a coincident timeout.
          if (deb_q != 3'b000) begin
            state_d = StTrack;
            mode_d  = map_code(deb_q);
            side_d  = next_side(deb_q, side_q);
          end else if (to_q == ToLast) begin
            state_d = StEnd;
            mode_d  = 3'b111;
          end else begin
            to_d = to_q + 32'd1;
          end
        end
        StEnd: begin
          mode_d = 3'b111;
          if (deb_q == 3'b010) begin
            state_d = StTrack;
            mode_d  = map_code(deb_q);
          end
        end
        default: begin
          state_d = StIdle;
          mode_d  = 3'b000;
        end
      endcase
    end
    lost_d = (state_d == StLost) || (state_d == StEnd);
    chg_d  = (mode_d != mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      deb_q    <= '0;
      to_q     <= '0;
      state_q  <= StIdle;
      side_q   <= SideNone;
      mode_q   <= '0;
      chg_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      deb_q    <= deb_d;
      to_q     <= to_d;
      state_q  <= state_d;
      side_q   <= side_d;
      mode_q   <= mode_d;
      chg_q    <= chg_d;
      lost_q   <= lost_d;
    end
  end

  assign bus.mode     = mode_q;
  assign bus.mode_chg = chg_q;
  assign bus.lost     = lost_q;

endmodule

// File: tb/tb_tracker_mode_gen.sv
// Directed bench for tracker_mode_gen with DEBOUNCE_CYCLES=4, LOST_TIMEOUT=10.
// Observed vector is {mode, mode_chg, lost}, sampled 1 ns after each rising edge.
module tb_tracker_mode_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  tracker_mode_gen_if trk ();

  tracker_mode_gen #(
    .DEBOUNCE_CYCLES(4),
    .LOST_TIMEOUT   (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(trk)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trk.en = 1'b0;
    trk.sensor = 3'b000;
    tick(3);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b000_0_0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b000_0_0);
    end
  endtask

  task automatic test_center();
    rst = 1'b0;
    trk.en = 1'b1;
    trk.sensor = 3'b010;
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b000_0_0) begin
      n_fail++;
      $display("FAIL center_idle_to_track: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b000_0_0);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b111_1_1) begin
      n_fail++;
      $display("FAIL center_initial_lost: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b111_1_1);
    end
    tick(4);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b111_0_1) begin
      n_fail++;
      $display("FAIL center_cycle6: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b111_0_1);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b101_1_0) begin
      n_fail++;
      $display("FAIL center_cycle7: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b101_1_0);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b101_0_0) begin
      n_fail++;
      $display("FAIL center_pulse_end: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b101_0_0);
    end
  endtask

  task automatic test_glitch();
    trk.sensor = 3'b011;
    tick(3);
    trk.sensor = 3'b010;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_checks++;
      if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b101_0_0) begin
        n_fail++;
        $display("FAIL glitch_hold[%0d]: got %b expected %b", i, {trk.mode, trk.mode_chg, trk.lost}, 5'b101_0_0);
      end
    end
  endtask

  task automatic test_lost_end();
    trk.sensor = 3'b011;
    tick(6);
    n_checks++;
    if (trk.mode !== 3'b101) begin
      n_fail++;
      $display("FAIL right_latency_early: got %b expected %b", trk.mode, 3'b101);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b011_1_0) begin
      n_fail++;
      $display("FAIL gentle_right: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b011_1_0);
    end
    trk.sensor = 3'b000;
    tick(7);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b001_1_1) begin
      n_fail++;
      $display("FAIL lost_right: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b001_1_1);
    end
    tick(9);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b001_0_1) begin
      n_fail++;
      $display("FAIL lost_before_timeout: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b001_0_1);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b111_1_1) begin
      n_fail++;
      $display("FAIL end_entry: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b111_1_1);
    end
    trk.sensor = 3'b100;
    tick(8);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b111_0_1) begin
      n_fail++;
      $display("FAIL end_ignores_left: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b111_0_1);
    end
    trk.sensor = 3'b010;
    tick(7);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b101_1_0) begin
      n_fail++;
      $display("FAIL end_exit_center: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b101_1_0);
    end
  endtask

  task automatic test_reacq_on_timeout();
    trk.sensor = 3'b110;
    tick(7);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b110_1_0) begin
      n_fail++;
      $display("FAIL gentle_left: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b110_1_0);
    end
    trk.sensor = 3'b000;
    tick(7);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b100_1_1) begin
      n_fail++;
      $display("FAIL lost_left: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b100_1_1);
    end
    tick(3);
    // Debounced 110 lands on the same edge the timeout counter hits its last value.
    trk.sensor = 3'b110;
    tick(6);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b100_0_1) begin
      n_fail++;
      $display("FAIL reacq_pre: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b100_0_1);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b110_1_0) begin
      n_fail++;
      $display("FAIL reacq_wins: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b110_1_0);
    end
  endtask

  task automatic test_en_drop();
    trk.sensor = 3'b000;
    tick(7);
    n_checks++;
    if ({trk.mode, trk.lost} !== 4'b100_1) begin
      n_fail++;
      $display("FAIL en_drop_setup: got %b expected %b", {trk.mode, trk.lost}, 4'b100_1);
    end
    tick(2);
    trk.en = 1'b0;
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b000_1_0) begin
      n_fail++;
      $display("FAIL en_drop_idle: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b000_1_0);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b000_0_0) begin
      n_fail++;
      $display("FAIL en_drop_hold: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b000_0_0);
    end
    trk.en = 1'b1;
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b000_0_0) begin
      n_fail++;
      $display("FAIL en_restart_track: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b000_0_0);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b111_1_1) begin
      n_fail++;
      $display("FAIL idle_clears_side: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b111_1_1);
    end
  endtask

  task automatic test_rst_mid_lost();
    trk.sensor = 3'b011;
    tick(7);
    n_checks++;
    if ({trk.mode, trk.lost} !== 4'b011_0) begin
      n_fail++;
      $display("FAIL rst_setup_right: got %b expected %b", {trk.mode, trk.lost}, 4'b011_0);
    end
    trk.sensor = 3'b000;
    tick(7);
    n_checks++;
    if ({trk.mode, trk.lost} !== 4'b001_1) begin
      n_fail++;
      $display("FAIL rst_setup_lost: got %b expected %b", {trk.mode, trk.lost}, 4'b001_1);
    end
    tick(3);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      n_checks++;
      if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b000_0_0) begin
        n_fail++;
        $display("FAIL rst_mid_lost[%0d]: got %b expected %b", i, {trk.mode, trk.mode_chg, trk.lost}, 5'b000_0_0);
      end
    end
    rst = 1'b0;
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b000_0_0) begin
      n_fail++;
      $display("FAIL rst_release: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b000_0_0);
    end
    tick(1);
    n_checks++;
    if ({trk.mode, trk.mode_chg, trk.lost} !== 5'b111_1_1) begin
      n_fail++;
      $display("FAIL rst_clears_side: got %b expected %b", {trk.mode, trk.mode_chg, trk.lost}, 5'b111_1_1);
    end
  endtask

  initial begin
    test_reset();
    test_center();
    test_glitch();
    test_lost_end();
    test_reacq_on_timeout();
    test_en_drop();
    test_rst_mid_lost();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
